mips_cpu_mem_arbiter: RTL and testbench

MIPS_CPU_MEM_ARBITER -- requirements
Module: mips_cpu_mem_arbiter

---
 rtl/mips_cpu_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mips_cpu_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_mem_arbiter.sv
// Shares one single-port memory between a MIPS core's instruction-fetch and data
// ports: round-robin grant, latched request, stall timeout and illegal-request abort.
module mips_cpu_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    output logic        instr_valid,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        data_valid,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        bus_error
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, INSTR, DATA, RESP} state_t;
    state_t state, state_next;

    logic             last_grant_data;  // 1 when the data port won the previous grant
    logic             resp_data;
    logic             resp_error;
    logic [CNT_W-1:0] stall_count;
    logic [31:0]      lat_address;
    logic [31:0]      lat_writedata;
    logic             lat_write;

    logic data_pending, grant_any, grant_data, illegal, timeout;

    assign data_pending = data_read | data_write;
    assign grant_any    = instr_req | data_pending;
    assign grant_data   = data_pending & (~instr_req | ~last_grant_data);
    assign illegal      = data_read & data_write;
    assign timeout      = mem_waitrequest && (stall_count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no branch can leave one unassigned and infer a latch.
        state_next    = state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_writedata = '0;
        mem_address   = lat_address & 32'hFFFF_FFFC;
        instr_valid   = 1'b0;
        data_valid    = 1'b0;
        bus_error     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    if (!grant_data)  state_next = INSTR;
                    else if (illegal) state_next = RESP;
                    else              state_next = DATA;
                end
            end
            INSTR: begin
                mem_read = 1'b1;
                if (!mem_waitrequest || timeout) state_next = RESP;
            end
            DATA: begin
                mem_read      = ~lat_write;
                mem_write     = lat_write;
                mem_writedata = lat_write ? lat_writedata : '0;
                if (!mem_waitrequest || timeout) state_next = RESP;
            end
            RESP: begin
                instr_valid = ~resp_data;
                data_valid  = resp_data;
                bus_error   = resp_error;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Strobes and pulses stay quiet for the whole reset cycle.
        if (reset) begin
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            instr_valid = 1'b0;
            data_valid  = 1'b0;
            bus_error   = 1'b0;
        end
    end

    // NOTE: the request latches carry no reset; they are always written at grant before any use.
    always_ff @(posedge clk) begin
        if (state == IDLE && grant_any) begin
            lat_address   <= grant_data ? data_address : instr_address;
            lat_writedata <= data_writedata;
            lat_write     <= grant_data & data_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_data <= 1'b0;
            resp_data       <= 1'b0;
            resp_error      <= 1'b0;
            stall_count     <= '0;
            instr_readdata  <= '0;
            data_readdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        last_grant_data <= grant_data;
                        resp_data       <= grant_data;
                        resp_error      <= grant_data & illegal;
                        stall_count     <= '0;
                        if (grant_data && illegal) data_readdata <= '0;
                    end
                end
                INSTR, DATA: begin
                    if (mem_waitrequest) begin
                        stall_count <= stall_count + CNT_W'(1);
                        if (timeout) begin
                            resp_error <= 1'b1;
                            if (resp_data) data_readdata  <= '0;
                            else           instr_readdata <= '0;
                        end
                    end else if (state == INSTR) begin
                        instr_readdata <= mem_readdata;
                    end else if (!lat_write) begin
                        data_readdata <= mem_readdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared every
// cycle against a transaction-level model of grants, strobe windows and responses.
module tb_mips_cpu_mem_arbiter;
    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_req = 1'b0;
    logic [31:0] instr_address = '0;
    logic [31:0] instr_readdata;
    logic        instr_valid;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_address = '0;
    logic [31:0] data_writedata = '0;
    logic [31:0] data_readdata;
    logic        data_valid;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest = 1'b0;
    logic        bus_error;

    always #5 clk = ~clk;

    mips_cpu_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_address(instr_address),
        .instr_readdata(instr_readdata), .instr_valid(instr_valid),
        .data_read(data_read), .data_write(data_write),
        .data_address(data_address), .data_writedata(data_writedata),
        .data_readdata(data_readdata), .data_valid(data_valid),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest), .bus_error(bus_error)
    );

    // Memory contents are a fixed function of the word address; junk while stalled.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;
    assign mem_readdata = mem_waitrequest ? 32'h0BAD_F00D : (ovr_en ? ovr_data : mem_fn(mem_address));

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stimulus policy
    bit rst_cmd = 1'b1;
    int post_pct = 0;
    bit allow_illegal = 1'b0;
    bit scramble = 1'b0;
    int plan_stalls = 0;

    // Requester queues (one outstanding request per port)
    bit          i_pend = 1'b0, d_pend = 1'b0;
    logic [31:0] i_addr_q = '0, d_addr_q = '0, d_wd_q = '0;
    bit          d_rd_q = 1'b0, d_wr_q = 1'b0;

    // Transaction model
    int          t = 0;
    bit          busy = 1'b0;
    int          g = 0, v = 0, last_strobe = 0, m_stalls = 0;
    bit          m_data = 1'b0, m_write = 1'b0, m_err = 1'b0, m_illegal = 1'b0;
    bit          m_last_data = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdval = '0;
    logic [31:0] m_ird = '0, m_drd = '0;

    // Observations for directed scenarios
    int          strobe_cnt = 0, err_cnt = 0, valid_cnt = 0;
    logic [15:0] order_log = '0;

    task automatic step();
        bit          was_busy;
        logic [4:0]  exp_ctrl;
        logic [4:0]  ctrl;
        int          r;
        @(negedge clk);
        t++;
        ctrl = {mem_read, mem_write, instr_valid, data_valid, bus_error};
        if (reset) begin
            busy = 1'b0; m_last_data = 1'b0; m_ird = '0; m_drd = '0;
            i_pend = 1'b0; d_pend = 1'b0;
            check("ctrl_in_reset", 32'(ctrl), 32'd0);
        end else begin
            exp_ctrl = '0;
            if (busy && t == v) begin
                if (m_data && (m_illegal || m_err)) m_drd = '0;
                else if (m_err)                     m_ird = '0;
                else if (!m_write) begin
                    if (m_data) m_drd = m_rdval;
                    else        m_ird = m_rdval;
                end
                exp_ctrl = {2'b00, !m_data, m_data, m_err};
            end else if (busy && t > g && t <= last_strobe) begin
                exp_ctrl = {!m_write, m_write, 3'b000};
                check("mem_address", mem_address, m_addr & 32'hFFFF_FFFC);
                if (m_write) check("mem_writedata", mem_writedata, m_wdata);
            end
            check("ctrl", 32'(ctrl), 32'(exp_ctrl));
        end
        check("instr_readdata", instr_readdata, m_ird);
        check("data_readdata", data_readdata, m_drd);

        if (mem_read | mem_write) strobe_cnt++;
        if (bus_error) err_cnt++;
        if (instr_valid | data_valid) begin
            valid_cnt++;
            order_log = {order_log[14:0], data_valid};
        end

        was_busy = busy;
        if (!reset && busy && t == v) begin
            busy = 1'b0;
            if (m_data) d_pend = 1'b0;
            else        i_pend = 1'b0;
        end

        // Drive inputs for the coming edge
        reset = rst_cmd;
        if (!i_pend && int'($urandom_range(99)) < post_pct) begin
            i_pend = 1'b1;
            i_addr_q = $urandom;
        end
        if (!d_pend && int'($urandom_range(99)) < post_pct) begin
            d_pend = 1'b1;
            r = int'($urandom_range(99));
            d_rd_q = (allow_illegal && r < 10) || r < 55;
            d_wr_q = (allow_illegal && r < 10) || r >= 55;
            d_addr_q = $urandom;
            d_wd_q = $urandom;
        end
        if (scramble && busy && !m_data) begin
            instr_req = 1'($urandom_range(1));
            instr_address = $urandom;
        end else begin
            instr_req = i_pend;
            instr_address = i_pend ? i_addr_q : $urandom;
        end
        if (scramble && busy && m_data) begin
            data_read = 1'($urandom_range(1));
            data_write = 1'($urandom_range(1));
            data_address = $urandom;
            data_writedata = $urandom;
        end else begin
            data_read = d_pend & d_rd_q;
            data_write = d_pend & d_wr_q;
            data_address = d_pend ? d_addr_q : $urandom;
            data_writedata = d_pend ? d_wd_q : $urandom;
        end
        if (busy && t > g && t <= last_strobe) mem_waitrequest = (t - g) <= m_stalls;
        else                                   mem_waitrequest = 1'($urandom_range(1));

        // Grant decision made by the edge that ends this cycle
        if (!was_busy && !rst_cmd && (i_pend || d_pend)) begin
            m_data = d_pend && (!i_pend || !m_last_data);
            m_last_data = m_data;
            busy = 1'b1;
            g = t;
            m_stalls = (plan_stalls >= 0) ? plan_stalls : int'($urandom_range(3));
            m_illegal = m_data && d_rd_q && d_wr_q;
            m_write = m_data && d_wr_q;
            m_addr = m_data ? d_addr_q : i_addr_q;
            m_wdata = d_wd_q;
            m_rdval = ovr_en ? ovr_data : mem_fn(m_addr & 32'hFFFF_FFFC);
            if (m_illegal) begin
                m_err = 1'b1; last_strobe = g; v = g + 1;
            end else if (m_stalls >= TO) begin
                m_err = 1'b1; last_strobe = g + TO; v = last_strobe + 1;
            end else begin
                m_err = 1'b0; last_strobe = g + 1 + m_stalls; v = last_strobe + 1;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_obs();
        strobe_cnt = 0; err_cnt = 0; valid_cnt = 0; order_log = '0;
    endtask

    task automatic do_reset();
        rst_cmd = 1'b1;
        run(2);
        rst_cmd = 1'b0;
        run(2);
    endtask

    task automatic post_instr(input logic [31:0] a);
        i_pend = 1'b1; i_addr_q = a;
    endtask

    task automatic post_data(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        d_pend = 1'b1; d_rd_q = rd; d_wr_q = wr; d_addr_q = a; d_wd_q = wd;
    endtask

    initial begin
        run(3);
        rst_cmd = 1'b0;
        run(2);

        // Boot fetch with zero wait states
        clear_obs();
        ovr_en = 1'b1; ovr_data = 32'h3C08_1234;
        post_instr(32'hBFC0_0000);
        run(5);
        check("boot_fetch_word", instr_readdata, 32'h3C08_1234);
        check("boot_fetch_valids", 32'(valid_cnt), 32'd1);
        ovr_en = 1'b0;

        // Simultaneous fetch and write after reset: data first
        do_reset();
        clear_obs();
        post_instr(32'h0000_0040);
        post_data(1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
        run(8);
        check("wr_then_fetch_order", 32'(order_log[1:0]), 32'h2);
        check("wr_then_fetch_valids", 32'(valid_cnt), 32'd2);

        // Both ports held continuously: D, I, D, I
        do_reset();
        clear_obs();
        post_pct = 100;
        run(12);
        post_pct = 0;
        check("rr_order", 32'(order_log[3:0]), 32'hA);
        check("rr_valids", 32'(valid_cnt), 32'd4);
        do_reset();

        // Unaligned read with three stall cycles
        clear_obs();
        plan_stalls = 3;
        post_data(1'b1, 1'b0, 32'h0000_2003, 32'h0);
        run(8);
        check("stall_strobe_cycles", 32'(strobe_cnt), 32'd4);
        check("stall_read_word", data_readdata, mem_fn(32'h0000_2000));

        // Waitrequest stuck high: timeout abort
        clear_obs();
        plan_stalls = 1000;
        post_data(1'b1, 1'b0, 32'h0000_4444, 32'h0);
        run(TO + 4);
        check("timeout_strobe_cycles", 32'(strobe_cnt), 32'(TO));
        check("timeout_errors", 32'(err_cnt), 32'd1);
        check("timeout_readdata", data_readdata, 32'h0);

        // Next request after the abort is served normally
        plan_stalls = 0;
        post_data(1'b1, 1'b0, 32'h0000_5554, 32'h0);
        run(4);
        check("after_timeout_word", data_readdata, mem_fn(32'h0000_5554));
        check("after_timeout_errors", 32'(err_cnt), 32'd1);

        // Read and write together: no memory access, error response
        clear_obs();
        post_data(1'b1, 1'b1, 32'h0000_3000, 32'h1111_2222);
        run(4);
        check("illegal_errors", 32'(err_cnt), 32'd1);
        check("illegal_strobes", 32'(strobe_cnt), 32'd0);
        check("illegal_readdata", data_readdata, 32'h0);

        // Reset while a write is stalled in DATA
        clear_obs();
        plan_stalls = 2;
        post_data(1'b0, 1'b1, 32'h0000_6000, 32'h1234_5678);
        run(2);
        rst_cmd = 1'b1;
        run(1);
        rst_cmd = 1'b0;
        run(4);
        check("reset_abort_valids", 32'(valid_cnt), 32'd0);
        check("reset_abort_strobes", 32'(strobe_cnt), 32'd2);

        // Randomized traffic with mid-transaction input changes and rare resets
        post_pct = 50;
        allow_illegal = 1'b1;
        scramble = 1'b1;
        plan_stalls = -1;
        for (int i = 0; i < 3000; i++) begin
            rst_cmd = ($urandom_range(499) == 0);
            step();
        end
        rst_cmd = 1'b0;
        post_pct = 0;
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
